// File: rtl/exe_pkg.sv
// rtl/exe_pkg.sv - shared widths, field offsets, exe_fun bits and multiplier states for the execute stage
package exe_pkg;

  localparam int ID_EXE_W  = 175;
  localparam int EXE_MEM_W = 123;

  // ID->EXE bus field positions
  localparam int ID_OP1_LSB      = 143;
  localparam int ID_OP2_LSB      = 111;
  localparam int ID_RD_LSB       = 106;
  localparam int ID_RD_WEN       = 105;
  localparam int ID_FUN_LSB      = 86;
  localparam int ID_MEM_WE       = 85;
  localparam int ID_MEM_RE       = 84;
  localparam int ID_WB_SEL_LSB   = 81;
  localparam int ID_PC_LSB       = 49;
  localparam int ID_MWD_LSB      = 17;
  localparam int ID_JMP          = 16;
  localparam int ID_CSR_CMD_LSB  = 12;
  localparam int ID_CSR_ADDR_LSB = 0;

  // one-hot exe_fun bit indices
  localparam int F_ADD   = 18;
  localparam int F_SUB   = 17;
  localparam int F_AND   = 16;
  localparam int F_OR    = 15;
  localparam int F_XOR   = 14;
  localparam int F_SLL   = 13;
  localparam int F_SRL   = 12;
  localparam int F_SRA   = 11;
  localparam int F_SLT   = 10;
  localparam int F_SLTU  = 9;
  localparam int F_BEQ   = 8;
  localparam int F_BNE   = 7;
  localparam int F_BGE   = 6;
  localparam int F_BGEU  = 5;
  localparam int F_BLT   = 4;
  localparam int F_BLTU  = 3;
  localparam int F_JALR  = 2;
  localparam int F_COPY1 = 1;
  localparam int F_MUL   = 0;

  localparam logic [2:0] WB_ALU = 3'd0;
  localparam logic [2:0] WB_MEM = 3'd1;
  localparam logic [2:0] WB_PC  = 3'd2;
  localparam logic [2:0] WB_CSR = 3'd3;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/exe_if.sv
// rtl/exe_if.sv - ID/EXE/MEM-facing signal bundle of the execute stage
interface exe_if;
  import exe_pkg::*;

  logic [ID_EXE_W-1:0]  id_exe_bus_in;
  logic [EXE_MEM_W-1:0] exe_mem_bus_out;
  logic                 br_jmp_flag;
  logic [31:0]          br_target;
  logic [5:0]           exe_id_data_bus;
  logic                 exe_busy;

  modport master (
    output id_exe_bus_in,
    input  exe_mem_bus_out, br_jmp_flag, br_target, exe_id_data_bus, exe_busy
  );

  modport slave (
    input  id_exe_bus_in,
    output exe_mem_bus_out, br_jmp_flag, br_target, exe_id_data_bus, exe_busy
  );

endinterface

// File: rtl/exe_mul_iter.sv
// rtl/exe_mul_iter.sv - iterative 32-cycle shift-add multiplier (low 32 bits, unsigned)
module exe_mul_iter
  import exe_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] product_o
);

  mul_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d, acc_q, acc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MUL_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      MUL_IDLE: begin
        // busy rises in the detect cycle so the input register holds the MUL
        if (start_i) begin
          busy_o  = 1'b1;
          a_d     = a_i;
          b_d     = b_i;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
        busy_o = 1'b1;
        if (b_q[0]) acc_d = acc_q + a_q;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = MUL_DONE;
      end
      MUL_DONE: begin
        done_o  = 1'b1;
        state_d = MUL_IDLE;
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  assign product_o = acc_q;

endmodule

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - RV32I execute stage: input register, ALU, branch/jump resolve, optional multiplier
// Optional feature macro: EXE_MUL_EN (iterative multiplier on exe_fun[0]).
module exe_stage
  import exe_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  exe_if.slave bus_io
);

  logic [ID_EXE_W-1:0] id_exe_q, id_exe_d;
  logic                exe_busy;

  assign id_exe_d = exe_busy ? id_exe_q : bus_io.id_exe_bus_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) id_exe_q <= '0;
    else        id_exe_q <= id_exe_d;
  end

  logic [31:0] op1, op2, pc, mwd;
  logic [18:0] fun;
  logic [4:0]  rd;
  logic [2:0]  wb_sel;
  logic [3:0]  csr_cmd;
  logic [11:0] csr_addr;
  logic        rd_wen, mem_we, mem_re, jmp_flag;

  assign op1      = id_exe_q[ID_OP1_LSB +: 32];
  assign op2      = id_exe_q[ID_OP2_LSB +: 32];
  assign rd       = id_exe_q[ID_RD_LSB +: 5];
  assign rd_wen   = id_exe_q[ID_RD_WEN];
  assign fun      = id_exe_q[ID_FUN_LSB +: 19];
  assign mem_we   = id_exe_q[ID_MEM_WE];
  assign mem_re   = id_exe_q[ID_MEM_RE];
  assign wb_sel   = id_exe_q[ID_WB_SEL_LSB +: 3];
  assign pc       = id_exe_q[ID_PC_LSB +: 32];
  assign mwd      = id_exe_q[ID_MWD_LSB +: 32];
  assign jmp_flag = id_exe_q[ID_JMP];
  assign csr_cmd  = id_exe_q[ID_CSR_CMD_LSB +: 4];
  assign csr_addr = id_exe_q[ID_CSR_ADDR_LSB +: 12];

  logic        mul_done;
  logic [31:0] mul_product;

`ifdef EXE_MUL_EN
  logic mul_busy;

  exe_mul_iter u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (fun[F_MUL]),
    .a_i       (op1),
    .b_i       (op2),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  assign exe_busy = mul_busy;
`else
  logic unused_mul_fun;

  assign unused_mul_fun = fun[F_MUL];
  assign mul_done       = 1'b0;
  assign mul_product    = '0;
  assign exe_busy       = 1'b0;
`endif

  logic [31:0] alu_out;

  always_comb begin
    alu_out = '0;
    if      (fun[F_ADD])   alu_out = op1 + op2;
    else if (fun[F_SUB])   alu_out = op1 - op2;
    else if (fun[F_AND])   alu_out = op1 & op2;
    else if (fun[F_OR])    alu_out = op1 | op2;
    else if (fun[F_XOR])   alu_out = op1 ^ op2;
    else if (fun[F_SLL])   alu_out = op1 << op2[4:0];
    else if (fun[F_SRL])   alu_out = op1 >> op2[4:0];
    else if (fun[F_SRA])   alu_out = $unsigned($signed(op1) >>> op2[4:0]);
    else if (fun[F_SLT])   alu_out = {31'd0, $signed(op1) < $signed(op2)};
    else if (fun[F_SLTU])  alu_out = {31'd0, op1 < op2};
    else if (fun[F_COPY1]) alu_out = op1;
    else if (fun[F_MUL])   alu_out = mul_done ? mul_product : 32'd0;
  end

  // branches compare rs1 (op1) against rs2, which ID routes through mem_wb_data
  logic br_eq, br_lt, br_ltu, br_taken;
  logic [31:0] jmp_sum;

  assign br_eq    = (op1 == mwd);
  assign br_lt    = ($signed(op1) < $signed(mwd));
  assign br_ltu   = (op1 < mwd);
  assign br_taken = (fun[F_BEQ]  &  br_eq)  | (fun[F_BNE]  & ~br_eq)  |
                    (fun[F_BGE]  & ~br_lt)  | (fun[F_BGEU] & ~br_ltu) |
                    (fun[F_BLT]  &  br_lt)  | (fun[F_BLTU] &  br_ltu);
  assign jmp_sum  = op1 + op2;

  assign bus_io.br_target       = jmp_flag ? (fun[F_JALR] ? (jmp_sum & ~32'd1) : jmp_sum)
                                           : (pc + op2);
  assign bus_io.br_jmp_flag     = ~exe_busy & (jmp_flag | br_taken);
  assign bus_io.exe_busy        = exe_busy;
  assign bus_io.exe_id_data_bus = {rd, mem_re & rd_wen};
  assign bus_io.exe_mem_bus_out = {alu_out, mwd, pc, rd,
                                   rd_wen & ~exe_busy, mem_we & ~exe_busy, mem_re & ~exe_busy,
                                   wb_sel, csr_cmd, csr_addr};

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the five-stage RV32I pipeline: the consumer of the 175-bit ID→EXE bus that the decode stage produces. It registers that bus, computes the ALU result, resolves branches and jumps (driving the `br_jmp_flag` redirect back to IF/ID), and reports load-hazard information to ID. It also forwards a 123-bit EXE→MEM bus and, optionally, runs an iterative 32-cycle multiplier that holds the front end while it works.

## Interface
- No parameters; widths are fixed by the shared package.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `id_exe_bus_in` in 175: fields {op1[174:143], op2[142:111], rd[110:106], rd_wen[105], exe_fun[104:86], mem_we[85], mem_re[84], wb_sel[83:81], pc[80:49], mem_wb_data[48:17], jmp_flag[16], csr_cmd[15:12], csr_addr[11:0]}.
- `exe_mem_bus_out` out 123: {alu_out[122:91], mem_wb_data[90:59], pc[58:27], rd[26:22], rd_wen[21], mem_we[20], mem_re[19], wb_sel[18:16], csr_cmd[15:12], csr_addr[11:0]}.
- `br_jmp_flag` out 1: taken branch or jump; redirect IF and squash ID this cycle.
- `br_target` out 32: redirect address.
- `exe_id_data_bus` out 6: {rd[5:1], load[0]}; load = mem_re & rd_wen of the registered instruction.
- `exe_busy` out 1: multiplier occupies EXE; IF/ID must hold.

## Operation
- Input register `id_exe_r` captures `id_exe_bus_in` on every edge unless `exe_busy`=1, in which case it holds. All outputs are combinational from `id_exe_r` and the multiplier state.
- `exe_fun` is one-hot: [18] ADD, [17] SUB, [16] AND, [15] OR, [14] XOR, [13] SLL, [12] SRL, [11] SRA, [10] SLT, [9] SLTU, [8] BEQ, [7] BNE, [6] BGE, [5] BGEU, [4] BLT, [3] BLTU, [2] JALR, [1] COPY1, [0] MUL.
- Shifts use op2[4:0]. SLT/SLTU produce 0/1. COPY1 sets alu_out=op1; this is the CSR write source. All-zero `exe_fun` sets alu_out=0. More than one bit set is illegal and the result is unspecified.
- Branches: ID places rs1 in op1, rs2 in mem_wb_data and the offset in op2. Compare op1 against mem_wb_data; br_target=pc+op2.
- Jumps: jmp_flag=1 forces br_jmp_flag=1. JAL: br_target=op1+op2, with op1=pc. JALR: br_target=(op1+op2)&~1. The link value is produced downstream from pc.
- br_jmp_flag = jmp_flag | (branch bit & compare true). It is forced to 0 while `exe_busy`.
- MUL FSM, with states IDLE/BUSY/DONE:
  - IDLE: when the registered instruction has MUL set, assert `exe_busy`, load the operands into the multiplier and go to BUSY with cnt=0.
  - BUSY: shift-add one bit per cycle. cnt increments 0..31, and cnt=31 goes to DONE.
  - DONE: `exe_busy`=0 and alu_out = low 32 bits of op1*op2 (unsigned), then IDLE on the next edge.
- While `exe_busy`=1, `exe_mem_bus_out` rd_wen/mem_we/mem_re are forced to 0 so MEM sees a bubble.
- Reset values: `id_exe_r`=0, FSM=IDLE, cnt=0. Every output is therefore 0, including br_target=0 and exe_id_data_bus=0.
- Reset asserted mid-multiply aborts the multiply with no partial writeback.

## Timing
- ALU, branch, jump: one cycle in EXE. `br_jmp_flag`/`br_target` are valid in the same cycle the instruction sits in `id_exe_r`.
- MUL occupies EXE for 34 cycles: 1 IDLE-detect + 32 BUSY + 1 DONE. `exe_busy` is high for the first 33 cycles.
- Input accepted on the edge following DONE.
- A squashed instruction arrives as the ID NOP (ADD, rd=x0, rd_wen=0) and needs no special handling.

## Configuration
- `EXE_MUL_EN` defined: MUL FSM and `exe_mul_iter` are instantiated.
- `EXE_MUL_EN` undefined:
  - No multiplier logic.
  - `exe_busy` is tied to 0.
  - exe_fun[0] behaves as all-zero, giving alu_out=0 while rd_wen passes through.

## Structure
- Shared package `exe_pkg`:
  - ID_EXE_W=175 and EXE_MEM_W=123.
  - Field offset localparams.
  - `exe_fun` bit indices.
  - wb_sel encodings.
- Sub-module `exe_mul_iter`: start/busy/done handshake, 32-bit shift-add core and cnt, owning the BUSY/DONE sequencing.
- The ALU and branch compare stay inline.

## Test plan
- ADD op1=0x7FFFFFFF, op2=1, rd=5, rd_wen=1 -> next cycle alu_out=0x80000000, rd=5, rd_wen=1, br_jmp_flag=0.
- BLT op1=0xFFFFFFFF, mem_wb_data=1, pc=0x100, op2=0x20 -> br_jmp_flag=1, br_target=0x120. Same operands with BLTU -> br_jmp_flag=0.
- JALR op1=0x1003, op2=4, jmp_flag=1 -> br_jmp_flag=1, br_target=0x1006.
- Load with rd=7, mem_re=1, rd_wen=1 -> exe_id_data_bus=0b001111.
- MUL op1=0x10001, op2=0x10001, EXE_MUL_EN defined -> exe_busy high for 33 cycles with rd_wen=0 on the bus, then alu_out=0x00020001. The following ADD is accepted one cycle after DONE.
- rst_n low at cnt=10 of a MUL -> all outputs 0 immediately. After release, FSM=IDLE and the next instruction executes normally.
